// File: rtl/study_model_pkg.sv
// study_pkg: shared types and constants for the study-mode block
package study_pkg;
  typedef enum logic [1:0] {IDLE, GUIDE, DONE} state_t;
  localparam logic [2:0] DO = 3'd1, RE = 3'd2, MI = 3'd3, FA = 3'd4, SO = 3'd5, LA = 3'd6, SI = 3'd7;
  localparam logic [4:0] LEN1 = 5'd14, LEN2 = 5'd15, LEN3 = 5'd14;
  localparam int MAX_LEN = 31;
endpackage

// File: rtl/study_model_if.sv
// study_model_if: key/select inputs and guidance outputs of the study block
interface study_model_if;
  logic [6:0] user_input;
  logic [2:0] user_selection;
  logic       user_store;
  logic       model_selection;
  logic [6:0] leds;
  logic [2:0] num_note;
  logic [4:0] cnt;
  logic [4:0] record;
  modport master (
    output user_input, user_selection, user_store, model_selection,
    input  leds, num_note, cnt, record
  );
  modport slave (
    input  user_input, user_selection, user_store, model_selection,
    output leds, num_note, cnt, record
  );
endinterface

// File: rtl/study_model_song_rom.sv
// song_rom: built-in song library, note number and length per song
module song_rom
  import study_pkg::*;
(
  input  logic [2:0] sel,
  input  logic [4:0] idx,
  output logic [2:0] note,
  output logic [4:0] len
);
  localparam logic [2:0] S1 [16] = '{DO, DO, SO, SO, LA, LA, SO, FA, FA, MI, MI, RE, RE, DO, 3'd0, 3'd0};
  localparam logic [2:0] S2 [16] = '{MI, MI, FA, SO, SO, FA, MI, RE, DO, DO, RE, MI, MI, RE, RE, 3'd0};
  localparam logic [2:0] S3 [16] = '{DO, RE, MI, FA, SO, LA, SI, SI, LA, SO, FA, MI, RE, DO, 3'd0, 3'd0};
  // invalid songs have length 0, so every index is out of range and yields note 0
  always_comb begin
    len = sel == 3'd1 ? LEN1 : sel == 3'd2 ? LEN2 : sel == 3'd3 ? LEN3 : 5'd0;
    note = idx >= len ? 3'd0 : sel == 3'd1 ? S1[idx[3:0]] : sel == 3'd2 ? S2[idx[3:0]] : S3[idx[3:0]];
  end
endmodule

// File: rtl/study_model.sv
// study_model: guided-practice mode, lights the next note and counts mistakes
module study_model
  import study_pkg::*;
(
  input logic clk,
  input logic rst_n,
  study_model_if.slave bus
);
  state_t state, state_a, state_n;
  logic [2:0] sel_reg, note_n, num_note;
  logic [6:0] prev_input, leds;
  logic [4:0] cnt, cnt_n, mistakes, mis_n, len_n, record;
  logic press, hit, reload;
  // press detection, song reload and progress through the current song
  always_comb begin
    press = bus.user_input != 7'd0 && (bus.user_input & (bus.user_input - 7'd1)) == 7'd0 && prev_input == 7'd0;
    hit = bus.user_input == leds;
    reload = bus.user_selection != sel_reg;
    state_a = state;
    cnt_n = cnt;
    mis_n = mistakes;
    if (reload) begin
      state_a = (bus.user_selection >= 3'd1 && bus.user_selection <= 3'd3) ? GUIDE : IDLE;
      cnt_n = 5'd0;
      mis_n = 5'd0;
    end else if (state == GUIDE && press) begin
      cnt_n = cnt + {4'd0, hit | bus.model_selection};
      mis_n = (!hit && mistakes != 5'(MAX_LEN)) ? mistakes + 5'd1 : mistakes;
    end
  end
  song_rom u_rom (.sel(bus.user_selection), .idx(cnt_n), .note(note_n), .len(len_n));
  assign state_n = (state_a == GUIDE && cnt_n == len_n) ? DONE : state_a;
  // all state and outputs registered; outputs reflect the post-edge note
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= IDLE;
      sel_reg <= 3'd0;
      prev_input <= 7'd0;
      cnt <= 5'd0;
      mistakes <= 5'd0;
      record <= 5'd0;
      leds <= 7'd0;
      num_note <= 3'd0;
    end else begin
      state <= state_n;
      sel_reg <= bus.user_selection;
      prev_input <= bus.user_input;
      cnt <= cnt_n;
      mistakes <= mis_n;
      if (state == DONE && bus.user_store) record <= mistakes;
      num_note <= state_n == GUIDE ? note_n : 3'd0;
      leds <= state_n == DONE ? 7'h7f : state_n == GUIDE ? 7'd1 << (note_n - 3'd1) : 7'd0;
    end
  end
  assign bus.leds = leds;
  assign bus.num_note = num_note;
  assign bus.cnt = cnt;
  assign bus.record = record;
endmodule

// File: tb/tb_study_model.sv
// tb_study_model: directed and random stimulus against a song-level reference model
module tb_study_model;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  study_model_if bus();
  study_model dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int tests = 0;
  int fails = 0;
  int song [3][15] = '{'{1, 1, 5, 5, 6, 6, 5, 4, 4, 3, 3, 2, 2, 1, 0},
                       '{3, 3, 4, 5, 5, 4, 3, 2, 1, 1, 2, 3, 3, 2, 2},
                       '{1, 2, 3, 4, 5, 6, 7, 7, 6, 5, 4, 3, 2, 1, 0}};
  int lens [3] = '{14, 15, 14};
  int m_sel, m_cnt, m_mis, m_rec;
  bit m_guide, m_done;
  logic [6:0] m_prev;
  logic [2:0] sel_v;
  logic ms_v;

  function automatic int cur_note();
    return m_guide ? song[m_sel-1][m_cnt] : 0;
  endfunction

  function automatic logic [6:0] key(int n);
    return n == 0 ? 7'd0 : 7'(1 << (n - 1));
  endfunction

  task automatic chk(string tag, logic [6:0] got, logic [6:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %b exp %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(logic [6:0] ui, logic store, logic rst);
    bit ev, right;
    bus.user_input = ui;
    bus.user_selection = sel_v;
    bus.model_selection = ms_v;
    bus.user_store = store;
    rst_n = rst;
    @(posedge clk);
    if (rst) begin
      m_sel = 0; m_cnt = 0; m_mis = 0; m_rec = 0; m_guide = 0; m_done = 0; m_prev = 0;
    end else begin
      ev = $countones(ui) == 1 && m_prev == 7'd0;
      if (m_done && store) m_rec = m_mis;
      if (int'(sel_v) != m_sel) begin
        m_sel = int'(sel_v); m_cnt = 0; m_mis = 0; m_done = 0;
        m_guide = m_sel >= 1 && m_sel <= 3;
      end else if (m_guide && ev) begin
        right = ui == key(cur_note());
        if (right || ms_v) m_cnt++;
        if (!right && m_mis < 31) m_mis++;
        if (m_cnt == lens[m_sel-1]) begin
          m_guide = 0;
          m_done = 1;
        end
      end
      m_prev = ui;
    end
    #1;
    chk("leds", bus.leds, m_done ? 7'h7f : key(cur_note()));
    chk("num_note", 7'(bus.num_note), 7'(cur_note()));
    chk("cnt", 7'(bus.cnt), 7'(m_cnt));
    chk("record", 7'(bus.record), 7'(m_rec));
  endtask

  task automatic press(logic [6:0] k);
    step(k, 1'b0, 1'b0);
    step(7'd0, 1'b0, 1'b0);
  endtask

  task automatic finish_song();
    for (int i = 0; i < 40 && !m_done; i++) press(key(cur_note()));
  endtask

  initial begin
    int r;
    logic [6:0] ui;
    sel_v = 3'd0;
    ms_v = 1'b0;
    step(7'd0, 1'b0, 1'b1);
    step(7'd0, 1'b0, 1'b1);
    repeat (10) step(7'd0, 1'b0, 1'b0);
    sel_v = 3'd2;
    step(7'd0, 1'b0, 1'b0);
    press(7'b0000100);
    press(7'b0000001);
    repeat (5) step(7'b0000010, 1'b0, 1'b0);
    step(7'd0, 1'b0, 1'b0);
    sel_v = 3'd1;
    step(7'd0, 1'b0, 1'b0);
    press(7'b1000000);
    finish_song();
    press(7'b0000001);
    step(7'd0, 1'b1, 1'b0);
    step(7'd0, 1'b0, 1'b0);
    sel_v = 3'd3;
    ms_v = 1'b1;
    step(7'd0, 1'b0, 1'b0);
    repeat (14) press(7'b0000001);
    step(7'd0, 1'b1, 1'b0);
    step(7'd0, 1'b0, 1'b0);
    ms_v = 1'b0;
    sel_v = 3'd0;
    step(7'd0, 1'b0, 1'b0);
    sel_v = 3'd1;
    step(7'd0, 1'b0, 1'b0);
    repeat (35) press(7'b0100000);
    finish_song();
    step(7'd0, 1'b1, 1'b0);
    sel_v = 3'd2;
    step(7'd0, 1'b0, 1'b0);
    repeat (5) press(key(cur_note()));
    step(7'd0, 1'b0, 1'b1);
    sel_v = 3'd0;
    step(7'd0, 1'b0, 1'b0);
    sel_v = 3'd1;
    step(7'd0, 1'b0, 1'b0);
    press(7'b0000001);
    sel_v = 3'd2;
    step(7'b0000100, 1'b0, 1'b0);
    step(7'd0, 1'b0, 1'b0);
    repeat (800) begin
      r = $urandom_range(0, 99);
      if (r < 2) sel_v = 3'($urandom_range(0, 7));
      if (r == 2) ms_v = ~ms_v;
      ui = r < 45 ? key(cur_note()) : r < 70 ? 7'd0 : 7'($urandom_range(0, 127));
      step(ui, r > 93 ? 1'b1 : 1'b0, r == 3 ? 1'b1 : 1'b0);
      if (r[0]) step(7'd0, 1'b0, 1'b0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
